obi_periph_bridge: RTL and testbench
====================================

Name: obi_periph_bridge

Overview:
- Fabric-side responder for the CPU peripheral bus (REQ/GNT/RVALID, OBI-style, in-order) that is carried over the CPU_IF tiles.
- Parametrised successor of the fixed 24-bit/32-bit peripheral pin wrapper.
- Adds request buffering, multiple outstanding transactions, a valid/ready user-side interface, and a response timeout that returns error data so the CPU never hangs on a dead user core.

Parameters:
- ADDR_W, 24, request address width.
- DATA_W, 32, data width; multiple of 8; BE width = DATA_W/8.
- DEPTH, 4, maximum granted-but-unanswered transactions; power of 2, >= 2; also the request FIFO depth.
- TIMEOUT, 255, cycles to wait for a user response before an error response is generated; 0 disables the timeout.
- ERR_DATA, 32'hDEADBEEF, RDATA value on a timed-out response; zero-extended or truncated to DATA_W.

Ports:
- CLK  in  1  fabric clock
- RST  in  1  asynchronous, active-high reset
- REQ  in  1  CPU request valid
- WE  in  1  CPU write enable
- BE  in  DATA_W/8  CPU byte enables
- ADDR  in  ADDR_W  CPU address
- WDATA  in  DATA_W  CPU write data
- GNT  out  1  request accepted
- RVALID  out  1  response valid, one-cycle pulse per transaction
- RDATA  out  DATA_W  response data
- U_VALID  out  1  user request available (FIFO head)
- U_READY  in  1  user accepts head request
- U_WE  out  1  head request write enable
- U_BE  out  DATA_W/8  head request byte enables
- U_ADDR  out  ADDR_W  head request address
- U_WDATA  out  DATA_W  head request write data
- U_RVALID  in  1  user response; required for reads and writes, in acceptance order
- U_RDATA  in  DATA_W  user response data; ignored for writes by the CPU
- ERR_CNT  out  8  number of timed-out transactions, saturating
- BUSY  out  1  outstanding count != 0

Behaviour:
- Reset values: RVALID=0, RDATA=0, U_VALID=0, ERR_CNT=0, BUSY=0; FIFO empty; all counters 0.
- GNT = REQ & !RST & (outstanding < DEPTH). GNT is combinational, same cycle as REQ.
- On REQ&GNT, {WE,BE,ADDR,WDATA} is pushed into the FIFO at the clock edge.
- U_VALID = FIFO not empty; U_* fields show the head entry. U_VALID&U_READY pops the entry and increments `inflight`.
- A request is visible on U_VALID at the earliest 1 cycle after GNT.
- outstanding = FIFO entries + inflight. It increments on grant and decrements on retire; grant and retire in the same cycle leave it unchanged.
- Response path:
  - U_RVALID with inflight>0 and drop==0 registers RVALID=1 and RDATA=U_RDATA on the next edge (1-cycle latency), then retires the transaction.
  - U_RVALID with inflight==0 and drop==0 is ignored.
- Timeout:
  - When TIMEOUT>0 and inflight>0, the wait counter increments each cycle without a U_RVALID; it clears on any response or retire.
  - When the counter reaches TIMEOUT, the bridge registers RVALID=1 and RDATA=ERR_DATA, retires the oldest inflight transaction, increments `drop`, and increments ERR_CNT (saturating at 255).
- Late responses: while drop>0, each U_RVALID decrements drop and produces no RVALID, keeping the in-order correspondence.
- Simultaneous events:
  - U_RVALID in the same cycle the counter hits TIMEOUT: the user response wins and no error is generated.
  - Push and pop in the same cycle on a full FIFO cannot occur, because GNT is blocked by the outstanding limit.
- Requests in the FIFO that have not been popped never time out.
- Reset mid-transaction clears everything immediately, including drop. The CPU is reset by the same warm-boot domain.

Decomposition:
- Package obi_periph_bridge_pkg holds the default ADDR_W/DATA_W, ERR_DATA, the request-entry field offsets (WE|BE|ADDR|WDATA packing) and the ERR_CNT width.
- One sub-module: sync_fifo (parametrised WIDTH/DEPTH, push/pop/full/empty, async active-high reset).
- Counters, timeout and response register live in the top.

Test Plan:
- Single read: REQ, WE=0, ADDR=0x000010; user pops next cycle and returns U_RDATA=0x12345678 two cycles later -> GNT in the REQ cycle, RVALID exactly 1 cycle after U_RVALID with RDATA=0x12345678, BUSY back to 0.
- Back-pressure: U_READY=0, 6 back-to-back REQs with DEPTH=4 -> exactly 4 GNTs, then GNT=0 until the first response retires.
- Ordering: 4 writes then 1 read, with user responses in order -> 5 RVALID pulses in the same order, and the read returns its U_RDATA.
- Timeout: TIMEOUT=16, pop a read and never respond -> RVALID with RDATA=0xDEADBEEF 17 cycles after the pop, ERR_CNT=1; a later U_RVALID is swallowed (no RVALID), and the next transaction completes normally.
- Race: U_RVALID asserted in the exact cycle the counter reaches TIMEOUT -> user data is returned and ERR_CNT stays 0.
- Reset: assert RST with 3 transactions outstanding -> all outputs 0 immediately; after release a new read completes normally.

Source files
------------

// File: rtl/obi_periph_bridge_pkg.sv
// obi_periph_bridge_pkg: shared defaults and request-entry packing for the peripheral bridge
package obi_periph_bridge_pkg;
    localparam int          ADDR_W_DEF   = 24;
    localparam int          DATA_W_DEF   = 32;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
    localparam int          ERR_CNT_W    = 8;
    // entry layout from LSB: WDATA | ADDR | BE | WE
    function automatic int off_addr(input int dw);
        return dw;
    endfunction
    function automatic int off_be(input int aw, input int dw);
        return dw + aw;
    endfunction
    function automatic int off_we(input int aw, input int dw);
        return dw + aw + dw / 8;
    endfunction
    function automatic int entry_w(input int aw, input int dw);
        return off_we(aw, dw) + 1;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers and a first-word-fall-through head
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             do_push, do_pop;
    always_comb begin
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
    assign rdata_o = mem_q[rd_q[AW-1:0]];
    assign empty_o = wr_q == rd_q;
    assign full_o  = wr_q[AW-1:0] == rd_q[AW-1:0] && wr_q[AW] != rd_q[AW];
endmodule

// File: rtl/obi_periph_bridge.sv
// obi_periph_bridge: OBI-style peripheral responder with request FIFO, outstanding limit
// and a response timeout that answers with error data when the user core goes silent.
module obi_periph_bridge
    import obi_periph_bridge_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int          DATA_W   = DATA_W_DEF,
    parameter int          DEPTH    = 4,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REQ,
    input  logic                 WE,
    input  logic [DATA_W/8-1:0]  BE,
    input  logic [ADDR_W-1:0]    ADDR,
    input  logic [DATA_W-1:0]    WDATA,
    output logic                 GNT,
    output logic                 RVALID,
    output logic [DATA_W-1:0]    RDATA,
    output logic                 U_VALID,
    input  logic                 U_READY,
    output logic                 U_WE,
    output logic [DATA_W/8-1:0]  U_BE,
    output logic [ADDR_W-1:0]    U_ADDR,
    output logic [DATA_W-1:0]    U_WDATA,
    input  logic                 U_RVALID,
    input  logic [DATA_W-1:0]    U_RDATA,
    output logic [ERR_CNT_W-1:0] ERR_CNT,
    output logic                 BUSY
);
    localparam int                OW       = $clog2(DEPTH + 1);
    localparam int                CW       = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam int                EW       = entry_w(ADDR_W, DATA_W);
    localparam int                OFF_A    = off_addr(DATA_W);
    localparam int                OFF_B    = off_be(ADDR_W, DATA_W);
    localparam int                OFF_W    = off_we(ADDR_W, DATA_W);
    localparam logic [OW-1:0]     MAX_OUT  = OW'(DEPTH);
    localparam logic [CW-1:0]     TMO      = CW'(TIMEOUT);
    localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

    logic [EW-1:0]        head;
    logic                 fifo_full, fifo_empty, pop, late, resp_ok, tmo, retire;
    logic [OW-1:0]        out_q, out_d, infl_q, infl_d;
    logic [CW-1:0]        wait_q, wait_d;
    logic [ERR_CNT_W-1:0] err_q, err_d, drop_q, drop_d;
    logic                 rvalid_q;
    logic [DATA_W-1:0]    rdata_q, rdata_d;

    assign GNT = REQ && !RST && out_q < MAX_OUT && !fifo_full;

    sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (GNT),
        .pop_i   (pop),
        .wdata_i ({WE, BE, ADDR, WDATA}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign U_VALID = !fifo_empty;
    assign pop     = U_VALID && U_READY;
    assign U_WE    = head[OFF_W];
    assign U_BE    = head[OFF_B +: DATA_W/8];
    assign U_ADDR  = head[OFF_A +: ADDR_W];
    assign U_WDATA = head[DATA_W-1:0];

    // responses owed for timed-out transactions are swallowed to keep ordering intact
    always_comb begin
        late    = U_RVALID && drop_q != '0;
        resp_ok = U_RVALID && infl_q != '0 && !late;
        tmo     = TIMEOUT > 0 && infl_q != '0 && !U_RVALID && wait_q == TMO;
        retire  = resp_ok || tmo;
        infl_d  = infl_q + OW'(pop) - OW'(retire);
        out_d   = out_q + OW'(GNT) - OW'(retire);
        wait_d  = (TIMEOUT == 0 || U_RVALID || retire || infl_q == '0) ? '0 : wait_q + 1'b1;
        drop_d  = drop_q + ERR_CNT_W'(tmo) - ERR_CNT_W'(late);
        err_d   = (tmo && err_q != '1) ? err_q + 1'b1 : err_q;
        rdata_d = tmo ? ERR_WORD : resp_ok ? U_RDATA : rdata_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_q    <= '0;
            infl_q   <= '0;
            wait_q   <= '0;
            drop_q   <= '0;
            err_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            out_q    <= out_d;
            infl_q   <= infl_d;
            wait_q   <= wait_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
            rvalid_q <= retire;
            rdata_q  <= rdata_d;
        end
    end

    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign ERR_CNT = err_q;
    assign BUSY    = out_q != '0;
endmodule

// File: tb/tb_obi_periph_bridge.sv
// tb_obi_periph_bridge: scenario tasks drive the bridge; expected responses are queued with
// their arrival cycle and matched against every RVALID pulse.
module tb_obi_periph_bridge;
    logic        CLK = 1'b0, RST = 1'b1, REQ = 1'b0, WE = 1'b0, U_READY = 1'b0, U_RVALID = 1'b0;
    logic [3:0]  BE = 4'hF;
    logic [23:0] ADDR = '0;
    logic [31:0] WDATA = '0, U_RDATA = '0;
    logic        GNT, RVALID, U_VALID, U_WE, BUSY;
    logic [31:0] RDATA, U_WDATA;
    logic [3:0]  U_BE;
    logic [23:0] U_ADDR;
    logic [7:0]  ERR_CNT;

    int checks = 0, failures = 0, cyc = 0;
    typedef struct { logic [31:0] d; int c; } exp_t;
    exp_t sb[$];

    obi_periph_bridge #(.TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .BE(BE), .ADDR(ADDR), .WDATA(WDATA),
        .GNT(GNT), .RVALID(RVALID), .RDATA(RDATA), .U_VALID(U_VALID), .U_READY(U_READY),
        .U_WE(U_WE), .U_BE(U_BE), .U_ADDR(U_ADDR), .U_WDATA(U_WDATA), .U_RVALID(U_RVALID),
        .U_RDATA(U_RDATA), .ERR_CNT(ERR_CNT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic tick();
        exp_t e;
        @(posedge CLK);
        #1;
        cyc++;
        if (RVALID) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rvalid_unexpected cyc=%0d rdata=%h", cyc, RDATA);
            end else begin
                e = sb.pop_front();
                if (RDATA !== e.d || cyc != e.c) begin
                    failures++;
                    $display("FAIL rvalid_match got cyc=%0d rdata=%h want cyc=%0d rdata=%h", cyc, RDATA, e.c, e.d);
                end
            end
        end
    endtask

    task automatic drain(input string name, input int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_rvalid pending=%0d want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic issue(input logic we, input logic [23:0] a, input logic [31:0] wd);
        REQ = 1'b1; WE = we; ADDR = a; WDATA = wd;
        #1;
        checks++;
        if (GNT !== 1'b1) begin failures++; $display("FAIL issue_gnt addr=%h got %b want 1", a, GNT); end
        tick();
        REQ = 1'b0;
    endtask

    task automatic serve(input logic [31:0] d);
        checks++;
        if (U_VALID !== 1'b1) begin failures++; $display("FAIL serve_u_valid got %b want 1", U_VALID); end
        U_READY = 1'b1;
        tick();
        U_READY = 1'b0; U_RVALID = 1'b1; U_RDATA = d;
        sb.push_back('{d, cyc + 1});
        tick();
        U_RVALID = 1'b0;
    endtask

    task automatic test_reset();
        REQ = 1'b1;
        repeat (2) tick();
        checks++;
        if ({RVALID, U_VALID, BUSY, GNT} !== 4'b0) begin failures++; $display("FAIL reset_flags got %b want 0000", {RVALID, U_VALID, BUSY, GNT}); end
        checks++;
        if (RDATA !== 32'h0) begin failures++; $display("FAIL reset_rdata got %h want 0", RDATA); end
        checks++;
        if (ERR_CNT !== 8'h0) begin failures++; $display("FAIL reset_err_cnt got %0d want 0", ERR_CNT); end
        REQ = 1'b0; RST = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        REQ = 1'b1; WE = 1'b0; ADDR = 24'h000010;
        #1;
        checks++;
        if (GNT !== 1'b1 || U_VALID !== 1'b0) begin failures++; $display("FAIL single_gnt got gnt=%b u_valid=%b want 1 0", GNT, U_VALID); end
        tick();
        REQ = 1'b0;
        checks++;
        if (U_VALID !== 1'b1 || U_ADDR !== 24'h000010 || U_WE !== 1'b0 || U_BE !== 4'hF)
        begin failures++; $display("FAIL single_head got v=%b a=%h we=%b be=%h want 1 000010 0 f", U_VALID, U_ADDR, U_WE, U_BE); end
        U_READY = 1'b1;
        tick();
        U_READY = 1'b0;
        tick();
        U_RVALID = 1'b1; U_RDATA = 32'h12345678;
        sb.push_back('{32'h12345678, cyc + 1});
        tick();
        U_RVALID = 1'b0;
        checks++;
        if (BUSY !== 1'b0) begin failures++; $display("FAIL single_busy got %b want 0", BUSY); end
        drain("single", 4);
    endtask

    task automatic test_back_pressure();
        int g = 0;
        U_READY = 1'b0; WE = 1'b1;
        for (int i = 0; i < 6; i++) begin
            REQ = 1'b1; ADDR = 24'(i); WDATA = 32'(i);
            #1;
            checks++;
            if (GNT !== (i < 4)) begin failures++; $display("FAIL bp_gnt req=%0d got %b want %b", i, GNT, i < 4); end
            if (GNT) g++;
            tick();
        end
        checks++;
        if (g != 4) begin failures++; $display("FAIL bp_gnt_count got %0d want 4", g); end
        U_READY = 1'b1;
        tick();
        U_READY = 1'b0;
        checks++;
        if (GNT !== 1'b0) begin failures++; $display("FAIL bp_gnt_after_pop got %b want 0", GNT); end
        U_RVALID = 1'b1; U_RDATA = 32'h0000_00B0;
        sb.push_back('{32'h0000_00B0, cyc + 1});
        tick();
        U_RVALID = 1'b0;
        checks++;
        if (GNT !== 1'b1) begin failures++; $display("FAIL bp_gnt_after_retire got %b want 1", GNT); end
        REQ = 1'b0;
        for (int i = 1; i < 4; i++) serve(32'h0000_00B0 + 32'(i));
        drain("bp", 4);
    endtask

    task automatic test_ordering();
        U_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 24'h000100 + 24'(i * 4), 32'h5000_0000 + 32'(i));
            checks++;
            if (U_ADDR !== 24'h000100 + 24'(i * 4) || U_WE !== 1'b1 || U_WDATA !== 32'h5000_0000 + 32'(i))
            begin failures++; $display("FAIL order_head i=%0d got a=%h we=%b wd=%h", i, U_ADDR, U_WE, U_WDATA); end
        end
        for (int i = 0; i < 4; i++) begin
            U_RVALID = 1'b1; U_RDATA = 32'hA000_0000 + 32'(i);
            sb.push_back('{32'hA000_0000 + 32'(i), cyc + 1});
            tick();
        end
        U_RVALID = 1'b0;
        issue(1'b0, 24'h000040, 32'h0);
        checks++;
        if (U_VALID !== 1'b1 || U_WE !== 1'b0) begin failures++; $display("FAIL order_read_head got v=%b we=%b want 1 0", U_VALID, U_WE); end
        tick();
        U_READY = 1'b0; U_RVALID = 1'b1; U_RDATA = 32'hCAFEF00D;
        sb.push_back('{32'hCAFEF00D, cyc + 1});
        tick();
        U_RVALID = 1'b0;
        drain("order", 4);
    endtask

    task automatic test_race();
        int p;
        issue(1'b0, 24'h000080, 32'h0);
        U_READY = 1'b1;
        tick();
        U_READY = 1'b0;
        p = cyc;
        while (cyc < p + 16) tick();
        U_RVALID = 1'b1; U_RDATA = 32'h5A5A5A5A;
        sb.push_back('{32'h5A5A5A5A, cyc + 1});
        tick();
        U_RVALID = 1'b0;
        repeat (3) tick();
        drain("race", 2);
        checks++;
        if (ERR_CNT !== 8'd0) begin failures++; $display("FAIL race_err_cnt got %0d want 0", ERR_CNT); end
    endtask

    task automatic test_timeout();
        issue(1'b0, 24'h000090, 32'h0);
        U_READY = 1'b1;
        tick();
        U_READY = 1'b0;
        sb.push_back('{32'hDEADBEEF, cyc + 17});
        drain("timeout", 30);
        checks++;
        if (ERR_CNT !== 8'd1) begin failures++; $display("FAIL timeout_err_cnt got %0d want 1", ERR_CNT); end
        U_RVALID = 1'b1; U_RDATA = 32'h11111111;
        tick();
        U_RVALID = 1'b0;
        checks++;
        if (RVALID !== 1'b0) begin failures++; $display("FAIL timeout_late_swallow got rvalid=%b want 0", RVALID); end
        tick();
        issue(1'b0, 24'h0000A0, 32'h0);
        serve(32'h22222222);
        drain("after_timeout", 4);
        checks++;
        if (ERR_CNT !== 8'd1) begin failures++; $display("FAIL timeout_err_cnt_hold got %0d want 1", ERR_CNT); end
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 24'h000200, 32'h0);
        U_READY = 1'b1;
        tick();
        U_READY = 1'b0;
        sb.push_back('{32'hDEADBEEF, cyc + 17});
        drain("mid_timeout", 30);
        for (int i = 0; i < 3; i++) issue(1'b1, 24'h000210 + 24'(i), 32'(i));
        U_READY = 1'b1;
        tick();
        U_READY = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if ({RVALID, U_VALID, BUSY} !== 3'b0 || RDATA !== 32'h0 || ERR_CNT !== 8'h0)
        begin failures++; $display("FAIL mid_reset got rv=%b uv=%b busy=%b rdata=%h err=%0d want all 0", RVALID, U_VALID, BUSY, RDATA, ERR_CNT); end
        REQ = 1'b1;
        #1;
        checks++;
        if (GNT !== 1'b0) begin failures++; $display("FAIL mid_reset_gnt got %b want 0", GNT); end
        REQ = 1'b0;
        #1;
        RST = 1'b0;
        tick();
        issue(1'b0, 24'h000300, 32'h0);
        serve(32'h33333333);
        drain("post_reset", 4);
        checks++;
        if (BUSY !== 1'b0 || ERR_CNT !== 8'd0) begin failures++; $display("FAIL post_reset_state got busy=%b err=%0d want 0 0", BUSY, ERR_CNT); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_pressure();
        test_ordering();
        test_race();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
